// File: rtl/matrix_64x64_fb_write_ctrl.sv
// Write-side controller for the 64x64 18bpp double-buffered LED matrix driver:
// arbitrates two pixel requesters, runs back-buffer fills and sequences page flips.
module matrix_64x64_fb_write_ctrl #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        q0_valid,
    output logic        q0_ready,
    input  logic [5:0]  q0_x,
    input  logic [5:0]  q0_y,
    input  logic [17:0] q0_data,

    input  logic        q1_valid,
    output logic        q1_ready,
    input  logic [5:0]  q1_x,
    input  logic [5:0]  q1_y,
    input  logic [17:0] q1_data,

    input  logic        fill_req,
    input  logic [17:0] fill_color,
    input  logic        flip_req,
    output logic        cmd_ready,
    output logic        flip_done,
    output logic        busy,

    output logic        wr,
    output logic [12:0] wr_addr,
    output logic [17:0] wr_data,
    output logic        buffer_select,
    input  logic        buffer_current
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FILL,
        ST_FLIP_WAIT
    } state_t;

    state_t      r_state;
    logic        r_wr;
    logic [12:0] r_wr_addr;
    logic [17:0] r_wr_data;
    logic        r_buffer_select;
    logic        r_flip_pend;
    logic        r_flip_done;
    logic [11:0] r_cnt;
    logic [17:0] r_fill_color;
    logic        r_last_winner;

    state_t      w_state_nxt;
    logic        w_wr_nxt;
    logic [12:0] w_wr_addr_nxt;
    logic [17:0] w_wr_data_nxt;
    logic        w_buffer_select_nxt;
    logic        w_flip_pend_nxt;
    logic        w_flip_done_nxt;
    logic [11:0] w_cnt_nxt;
    logic [17:0] w_fill_color_nxt;
    logic        w_last_winner_nxt;

    logic        w_back;
    logic        w_cmd_ready;
    logic        w_cmd_take;
    logic        w_xfer_en;
    logic        w_gnt0;
    logic        w_gnt1;

    assign w_back      = ~r_buffer_select;
    assign w_cmd_ready = !rst && (r_state == ST_RUN) && !r_flip_pend;
    assign w_cmd_take  = w_cmd_ready && (fill_req || flip_req);
    // A cycle that accepts a command carries no pixel transfer.
    assign w_xfer_en   = w_cmd_ready && !w_cmd_take;

    // On a tie, round-robin hands the grant to whoever did not win last.
    assign w_gnt1 = q1_valid && (!q0_valid || (RR_ENABLE && !r_last_winner));
    assign w_gnt0 = q0_valid && !w_gnt1;

    assign q0_ready      = w_xfer_en && w_gnt0;
    assign q1_ready      = w_xfer_en && w_gnt1;
    assign cmd_ready     = w_cmd_ready;
    assign busy          = (r_state != ST_RUN) || r_flip_pend;
    assign flip_done     = r_flip_done;
    assign wr            = r_wr;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign buffer_select = r_buffer_select;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt         = r_state;
        w_wr_nxt            = 1'b0;
        w_wr_addr_nxt       = r_wr_addr;
        w_wr_data_nxt       = r_wr_data;
        w_buffer_select_nxt = r_buffer_select;
        w_flip_pend_nxt     = r_flip_pend;
        w_flip_done_nxt     = 1'b0;
        w_cnt_nxt           = r_cnt;
        w_fill_color_nxt    = r_fill_color;
        w_last_winner_nxt   = r_last_winner;

        unique case (r_state)
            ST_RUN: begin
                if (r_flip_pend) begin
                    w_buffer_select_nxt = ~r_buffer_select;
                    w_flip_pend_nxt     = 1'b0;
                    w_state_nxt         = ST_FLIP_WAIT;
                end else if (w_cmd_ready && fill_req) begin
                    // The first fill word is issued on acceptance so writes start next cycle.
                    w_fill_color_nxt = fill_color;
                    w_wr_nxt         = 1'b1;
                    w_wr_addr_nxt    = {w_back, 12'd0};
                    w_wr_data_nxt    = fill_color;
                    w_cnt_nxt        = 12'd1;
                    w_flip_pend_nxt  = flip_req;
                    w_state_nxt      = ST_FILL;
                end else if (w_cmd_ready && flip_req) begin
                    w_buffer_select_nxt = ~r_buffer_select;
                    w_state_nxt         = ST_FLIP_WAIT;
                end else if (q0_ready) begin
                    w_wr_nxt          = 1'b1;
                    w_wr_addr_nxt     = {w_back, q0_y, q0_x};
                    w_wr_data_nxt     = q0_data;
                    w_last_winner_nxt = 1'b0;
                end else if (q1_ready) begin
                    w_wr_nxt          = 1'b1;
                    w_wr_addr_nxt     = {w_back, q1_y, q1_x};
                    w_wr_data_nxt     = q1_data;
                    w_last_winner_nxt = 1'b1;
                end
            end
            ST_FILL: begin
                w_wr_nxt      = 1'b1;
                w_wr_addr_nxt = {w_back, r_cnt};
                w_wr_data_nxt = r_fill_color;
                w_cnt_nxt     = r_cnt + 12'd1;
                // A pending flip is launched from RUN on the following cycle.
                if (r_cnt == 12'hFFF) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLIP_WAIT: begin
                if (buffer_current == r_buffer_select) begin
                    w_flip_done_nxt = 1'b1;
                    w_state_nxt     = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_wr            <= 1'b0;
            r_wr_addr       <= 13'd0;
            r_wr_data       <= 18'd0;
            r_buffer_select <= 1'b0;
            r_flip_pend     <= 1'b0;
            r_flip_done     <= 1'b0;
            r_cnt           <= 12'd0;
            r_fill_color    <= 18'd0;
            r_last_winner   <= 1'b1;
        end else begin
            r_state         <= w_state_nxt;
            r_wr            <= w_wr_nxt;
            r_wr_addr       <= w_wr_addr_nxt;
            r_wr_data       <= w_wr_data_nxt;
            r_buffer_select <= w_buffer_select_nxt;
            r_flip_pend     <= w_flip_pend_nxt;
            r_flip_done     <= w_flip_done_nxt;
            r_cnt           <= w_cnt_nxt;
            r_fill_color    <= w_fill_color_nxt;
            r_last_winner   <= w_last_winner_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_64x64_fb_write_ctrl.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus;
// table vectors, a randomized model comparison and fill/flip/reset sequences.
module tb_matrix_64x64_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        q0_valid = 1'b0, q1_valid = 1'b0;
    logic [5:0]  q0_x = '0, q0_y = '0, q1_x = '0, q1_y = '0;
    logic [17:0] q0_data = '0, q1_data = '0;
    logic        fill_req = 1'b0, flip_req = 1'b0;
    logic [17:0] fill_color = '0;
    logic        buffer_current = 1'b0;

    logic        q0_ready_rr, q1_ready_rr, cmd_ready_rr, flip_done_rr, busy_rr, wr_rr, bs_rr;
    logic [12:0] wr_addr_rr;
    logic [17:0] wr_data_rr;
    logic        q0_ready_fp, q1_ready_fp, cmd_ready_fp, flip_done_fp, busy_fp, wr_fp, bs_fp;
    logic [12:0] wr_addr_fp;
    logic [17:0] wr_data_fp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matrix_64x64_fb_write_ctrl #(.RR_ENABLE(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .q0_valid(q0_valid), .q0_ready(q0_ready_rr), .q0_x(q0_x), .q0_y(q0_y), .q0_data(q0_data),
        .q1_valid(q1_valid), .q1_ready(q1_ready_rr), .q1_x(q1_x), .q1_y(q1_y), .q1_data(q1_data),
        .fill_req(fill_req), .fill_color(fill_color), .flip_req(flip_req),
        .cmd_ready(cmd_ready_rr), .flip_done(flip_done_rr), .busy(busy_rr),
        .wr(wr_rr), .wr_addr(wr_addr_rr), .wr_data(wr_data_rr),
        .buffer_select(bs_rr), .buffer_current(buffer_current)
    );

    matrix_64x64_fb_write_ctrl #(.RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .q0_valid(q0_valid), .q0_ready(q0_ready_fp), .q0_x(q0_x), .q0_y(q0_y), .q0_data(q0_data),
        .q1_valid(q1_valid), .q1_ready(q1_ready_fp), .q1_x(q1_x), .q1_y(q1_y), .q1_data(q1_data),
        .fill_req(fill_req), .fill_color(fill_color), .flip_req(flip_req),
        .cmd_ready(cmd_ready_fp), .flip_done(flip_done_fp), .busy(busy_fp),
        .wr(wr_fp), .wr_addr(wr_addr_fp), .wr_data(wr_data_fp),
        .buffer_select(bs_fp), .buffer_current(buffer_current)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0_valid = 1'b1;
        q1_valid = 1'b1;
        fill_req = 1'b0;
        flip_req = 1'b0;
        tick();
        check("rst_q0_ready", q0_ready_rr, 0);
        check("rst_q1_ready", q1_ready_rr, 0);
        check("rst_cmd_ready", cmd_ready_rr, 0);
        tick();
        rst = 1'b0;
        q0_valid = 1'b0;
        q1_valid = 1'b0;
        #1;
        check("rst_wr", wr_rr, 0);
        check("rst_wr_addr", wr_addr_rr, 0);
        check("rst_wr_data", wr_data_rr, 0);
        check("rst_bs", bs_rr, 0);
        check("rst_flip_done", flip_done_rr, 0);
        check("rst_busy", busy_rr, 0);
        check("rst_cmd_ready_after", cmd_ready_rr, 1);
    endtask

    typedef struct {
        logic        v0, v1;
        logic [5:0]  x0, y0, x1, y1;
        logic [17:0] d0, d1;
        int          g_rr;   // expected grant: 0, 1, or 2 = none
        int          g_fp;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [12:0] ea;
        logic [17:0] ed;
        logic [17:0] color;
        int          m_last;
        int          g_rr, g_fp;
        logic        e_wr_rr, e_wr_fp;
        logic [12:0] e_a_rr, e_a_fp;
        logic [17:0] e_d_rr, e_d_fp;

        vecs[0] = '{1, 1, 6'd5,  6'd40, 6'd1,  6'd2,  18'h3FFFF, 18'h00011, 0, 0};
        vecs[1] = '{1, 1, 6'd9,  6'd9,  6'd10, 6'd11, 18'h12345, 18'h2ABCD, 1, 0};
        vecs[2] = '{0, 1, 6'd3,  6'd4,  6'd20, 6'd33, 18'h00001, 18'h15555, 1, 1};
        vecs[3] = '{1, 1, 6'd17, 6'd31, 6'd0,  6'd1,  18'h0AAAA, 18'h00002, 0, 0};
        vecs[4] = '{1, 0, 6'd62, 6'd32, 6'd5,  6'd5,  18'h00FC0, 18'h3F000, 0, 0};
        vecs[5] = '{0, 0, 6'd1,  6'd1,  6'd2,  6'd2,  18'h11111, 18'h22222, 2, 2};
        vecs[6] = '{1, 1, 6'd12, 6'd13, 6'd44, 6'd55, 18'h0003F, 18'h3FFC0, 1, 0};
        vecs[7] = '{1, 1, 6'd63, 6'd63, 6'd7,  6'd8,  18'h2DEAD, 18'h1BEEF, 0, 0};
        vecs[8] = '{0, 1, 6'd30, 6'd30, 6'd0,  6'd0,  18'h00000, 18'h3FFFF, 1, 1};

        do_reset();

        // Table vectors from reset: buffer_select = 0, so writes land in buffer 1.
        for (int i = 0; i < 9; i++) begin
            q0_valid = vecs[i].v0; q1_valid = vecs[i].v1;
            q0_x = vecs[i].x0; q0_y = vecs[i].y0; q0_data = vecs[i].d0;
            q1_x = vecs[i].x1; q1_y = vecs[i].y1; q1_data = vecs[i].d1;
            #1;
            check("tbl_q0_ready_rr", q0_ready_rr, vecs[i].g_rr == 0);
            check("tbl_q1_ready_rr", q1_ready_rr, vecs[i].g_rr == 1);
            check("tbl_q0_ready_fp", q0_ready_fp, vecs[i].g_fp == 0);
            check("tbl_q1_ready_fp", q1_ready_fp, vecs[i].g_fp == 1);
            tick();
            check("tbl_wr_rr", wr_rr, vecs[i].g_rr != 2);
            check("tbl_wr_fp", wr_fp, vecs[i].g_fp != 2);
            if (vecs[i].g_rr != 2) begin
                ea = (vecs[i].g_rr == 0) ? {1'b1, vecs[i].y0, vecs[i].x0} : {1'b1, vecs[i].y1, vecs[i].x1};
                ed = (vecs[i].g_rr == 0) ? vecs[i].d0 : vecs[i].d1;
                check("tbl_addr_rr", wr_addr_rr, ea);
                check("tbl_data_rr", wr_data_rr, ed);
            end
            if (vecs[i].g_fp != 2) begin
                ea = (vecs[i].g_fp == 0) ? {1'b1, vecs[i].y0, vecs[i].x0} : {1'b1, vecs[i].y1, vecs[i].x1};
                ed = (vecs[i].g_fp == 0) ? vecs[i].d0 : vecs[i].d1;
                check("tbl_addr_fp", wr_addr_fp, ea);
                check("tbl_data_fp", wr_data_fp, ed);
            end
            if (i == 0) check("first_write_addr_1A05", wr_addr_rr, 13'h1A05);
        end
        q0_valid = 1'b0; q1_valid = 1'b0;

        // Randomized arbitration against the reference model.
        do_reset();
        m_last = 1;
        e_wr_rr = 1'b0; e_wr_fp = 1'b0;
        e_a_rr = '0; e_a_fp = '0; e_d_rr = '0; e_d_fp = '0;
        for (int c = 0; c < 300; c++) begin
            tick();
            check("rnd_wr_rr", wr_rr, e_wr_rr);
            check("rnd_wr_fp", wr_fp, e_wr_fp);
            if (e_wr_rr) begin
                check("rnd_addr_rr", wr_addr_rr, e_a_rr);
                check("rnd_data_rr", wr_data_rr, e_d_rr);
            end
            if (e_wr_fp) begin
                check("rnd_addr_fp", wr_addr_fp, e_a_fp);
                check("rnd_data_fp", wr_data_fp, e_d_fp);
            end
            q0_valid = ($urandom_range(0, 3) != 0);
            q1_valid = ($urandom_range(0, 3) != 0);
            q0_x = 6'($urandom_range(0, 63)); q0_y = 6'($urandom_range(0, 63));
            q1_x = 6'($urandom_range(0, 63)); q1_y = 6'($urandom_range(0, 63));
            q0_data = 18'($urandom); q1_data = 18'($urandom);
            #1;
            if (!q0_valid && !q1_valid) begin
                g_rr = 2; g_fp = 2;
            end else if (q0_valid && !q1_valid) begin
                g_rr = 0; g_fp = 0;
            end else if (!q0_valid && q1_valid) begin
                g_rr = 1; g_fp = 1;
            end else begin
                g_rr = (m_last == 1) ? 0 : 1;
                g_fp = 0;
            end
            check("rnd_q0_ready_rr", q0_ready_rr, g_rr == 0);
            check("rnd_q1_ready_rr", q1_ready_rr, g_rr == 1);
            check("rnd_q0_ready_fp", q0_ready_fp, g_fp == 0);
            check("rnd_q1_ready_fp", q1_ready_fp, g_fp == 1);
            e_wr_rr = (g_rr != 2);
            e_wr_fp = (g_fp != 2);
            e_a_rr = (g_rr == 0) ? {1'b1, q0_y, q0_x} : {1'b1, q1_y, q1_x};
            e_d_rr = (g_rr == 0) ? q0_data : q1_data;
            e_a_fp = (g_fp == 0) ? {1'b1, q0_y, q0_x} : {1'b1, q1_y, q1_x};
            e_d_fp = (g_fp == 0) ? q0_data : q1_data;
            if (g_rr != 2) m_last = g_rr;
        end
        tick();
        check("rnd_last_wr_rr", wr_rr, e_wr_rr);
        if (e_wr_rr) check("rnd_last_addr_rr", wr_addr_rr, e_a_rr);
        q0_valid = 1'b0; q1_valid = 1'b0;

        // Fill at buffer_select = 0: 4096 writes to 0x1000..0x1FFF, requesters blocked.
        q0_valid = 1'b1; q1_valid = 1'b1;
        fill_color = 18'h00FC0;
        fill_req = 1'b1;
        #1;
        check("fill_accept_cmd_ready", cmd_ready_rr, 1);
        check("fill_accept_q0_ready", q0_ready_rr, 0);
        check("fill_accept_q1_ready", q1_ready_rr, 0);
        for (int i = 0; i < 4096; i++) begin
            tick();
            if (i == 0) begin
                fill_req = 1'b0;
                fill_color = 18'h2AAAA;
            end
            if (i == 4095) begin
                q0_valid = 1'b0; q1_valid = 1'b0;
            end
            #1;
            check("fill_wr", wr_rr, 1);
            check("fill_addr", wr_addr_rr, 13'h1000 + 13'(i));
            check("fill_data", wr_data_rr, 18'h00FC0);
            check("fill_addr_fp", wr_addr_fp, 13'h1000 + 13'(i));
            check("fill_q0_ready", q0_ready_rr, 0);
            check("fill_q1_ready", q1_ready_rr, 0);
            check("fill_busy", busy_rr, i != 4095);
        end
        tick();
        check("fill_end_wr", wr_rr, 0);
        check("fill_end_busy", busy_rr, 0);
        check("fill_end_cmd_ready", cmd_ready_rr, 1);
        check("fill_end_bs", bs_rr, 0);

        // Flip with the driver lagging 500 cycles.
        buffer_current = 1'b0;
        flip_req = 1'b1;
        #1;
        check("flip_accept_cmd_ready", cmd_ready_rr, 1);
        for (int k = 0; k < 500; k++) begin
            tick();
            if (k == 0) begin
                flip_req = 1'b0;
                q0_valid = 1'b1;
                q0_x = 6'd7; q0_y = 6'd3; q0_data = 18'h00155;
            end
            #1;
            check("flipw_bs", bs_rr, 1);
            check("flipw_wr", wr_rr, 0);
            check("flipw_done", flip_done_rr, 0);
            check("flipw_q0_ready", q0_ready_rr, 0);
            check("flipw_busy", busy_rr, 1);
            check("flipw_cmd_ready", cmd_ready_rr, 0);
        end
        q0_valid = 1'b0;
        buffer_current = 1'b1;
        tick();
        check("flip_done_pulse", flip_done_rr, 1);
        check("flip_done_pulse_fp", flip_done_fp, 1);
        tick();
        check("flip_done_drop", flip_done_rr, 0);
        check("flip_after_busy", busy_rr, 0);
        check("flip_after_cmd_ready", cmd_ready_rr, 1);
        q0_valid = 1'b1;
        #1;
        check("flip_after_q0_ready", q0_ready_rr, 1);
        tick();
        q0_valid = 1'b0;
        check("flip_after_wr", wr_rr, 1);
        check("flip_after_addr", wr_addr_rr, 13'h00C7);
        check("flip_after_data", wr_data_rr, 18'h00155);

        // Fill and flip together: back buffer 0 filled, then displayed.
        color = 18'($urandom);
        fill_color = color;
        fill_req = 1'b1;
        flip_req = 1'b1;
        q1_valid = 1'b1;
        #1;
        check("ff_accept_cmd_ready", cmd_ready_rr, 1);
        for (int i = 0; i < 4096; i++) begin
            tick();
            if (i == 0) begin
                fill_req = 1'b0;
                flip_req = 1'b0;
            end
            #1;
            check("ff_wr", wr_rr, 1);
            check("ff_addr", wr_addr_rr, 13'(i));
            check("ff_data", wr_data_rr, color);
            check("ff_bs", bs_rr, 1);
            check("ff_cmd_ready", cmd_ready_rr, 0);
            check("ff_q1_ready", q1_ready_rr, 0);
            check("ff_busy", busy_rr, 1);
        end
        tick();
        check("ff_toggle_bs", bs_rr, 0);
        check("ff_toggle_wr", wr_rr, 0);
        check("ff_toggle_cmd_ready", cmd_ready_rr, 0);
        check("ff_toggle_q1_ready", q1_ready_rr, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("ffw_done", flip_done_rr, 0);
            check("ffw_wr", wr_rr, 0);
            check("ffw_cmd_ready", cmd_ready_rr, 0);
        end
        q1_valid = 1'b0;
        buffer_current = 1'b0;
        tick();
        check("ff_flip_done", flip_done_rr, 1);
        tick();
        check("ff_flip_done_drop", flip_done_rr, 0);
        check("ff_cmd_ready_back", cmd_ready_rr, 1);

        // Bring buffer_select to 1, then reset in the middle of a fill+flip.
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        buffer_current = 1'b1;
        check("pre_rst_bs", bs_rr, 1);
        tick();
        check("pre_rst_flip_done", flip_done_rr, 1);
        tick();
        fill_req = 1'b1;
        flip_req = 1'b1;
        fill_color = 18'h3C3C3;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i == 0) begin
                fill_req = 1'b0;
                flip_req = 1'b0;
            end
            check("rstf_addr", wr_addr_rr, 13'(i));
        end
        rst = 1'b1;
        tick();
        check("rstf_wr", wr_rr, 0);
        check("rstf_bs", bs_rr, 0);
        check("rstf_done", flip_done_rr, 0);
        rst = 1'b0;
        #1;
        check("rstf_busy", busy_rr, 0);
        check("rstf_cmd_ready", cmd_ready_rr, 1);
        buffer_current = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rstf_idle_done", flip_done_rr, 0);
            check("rstf_idle_wr", wr_rr, 0);
        end
        q1_valid = 1'b1;
        q1_x = 6'd63; q1_y = 6'd31; q1_data = 18'h0F0F0;
        #1;
        check("rstf_q1_ready", q1_ready_rr, 1);
        tick();
        q1_valid = 1'b0;
        check("rstf_q1_wr", wr_rr, 1);
        check("rstf_q1_addr", wr_addr_rr, 13'h17FF);
        check("rstf_q1_data", wr_data_rr, 18'h0F0F0);
        tick();
        check("rstf_q1_idle", wr_rr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
